memory_controller: RTL and testbench

- Sole owner of the byte-wide RAM/IO port.
- Serves three clients:
  - load requests issued by the load/store buffer (registered lsb_mem_* outputs);
  - committed store requests from the ROB;
  - 32-bit instruction fetches from the fetcher.
- Returns load results on the mem_data_ready/mem_data/mem_id broadcast bus consumed by LSB, RS and ROB.
- Serialises every access into 1–4 byte RAM cycles.

---
 rtl/memory_controller.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_memory_controller.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_controller.sv
// memory_controller: sole owner of the byte-wide RAM/IO port.
// Serialises loads, committed stores and fetches into byte cycles.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif
`ifndef INST_OP_WIDTH
`define INST_OP_WIDTH 6
`endif
`ifndef OP_LB
`define OP_LB  6'd0
`define OP_LH  6'd1
`define OP_LW  6'd2
`define OP_LBU 6'd3
`define OP_LHU 6'd4
`define OP_SB  6'd5
`define OP_SH  6'd6
`define OP_SW  6'd7
`endif

module memory_controller #(
   parameter logic [`XLEN-1:0] IO_ADDR = 32'h30000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rdy,
   input  logic                       flush,
   input  logic                       io_buffer_full,
   input  logic                       lsb_mem_enable,
   input  logic [`INST_OP_WIDTH-1:0]  lsb_mem_op,
   input  logic [`XLEN-1:0]           lsb_mem_addr,
   input  logic [`ROB_SIZE_WIDTH-1:0] lsb_mem_id,
   input  logic                       rob_store_enable,
   input  logic [`INST_OP_WIDTH-1:0]  rob_store_op,
   input  logic [`XLEN-1:0]           rob_store_addr,
   input  logic [`XLEN-1:0]           rob_store_data,
   input  logic                       if_enable,
   input  logic [`XLEN-1:0]           if_addr,
   input  logic [7:0]                 mem_din,
   output logic [7:0]                 mem_dout,
   output logic [`XLEN-1:0]           mem_a,
   output logic                       mem_wr,
   output logic                       mem_busy,
   output logic                       mem_data_ready,
   output logic [`XLEN-1:0]           mem_data,
   output logic [`ROB_SIZE_WIDTH-1:0] mem_id,
   output logic                       if_ready,
   output logic [31:0]                if_inst
);
   localparam int XL  = `XLEN;
   localparam int OPW = `INST_OP_WIDTH;
   localparam int IDW = `ROB_SIZE_WIDTH;
   localparam logic [XL-1:0] ONE = 1;

   typedef enum logic [1:0] {IDLE, LOAD, STORE, FETCH} state_t;

   state_t         state_q, state_d;
   logic [2:0]     cnt_q, cnt_d;
   logic [2:0]     len_q, len_d;
   logic [OPW-1:0] op_q, op_d;
   logic [IDW-1:0] id_q, id_d;
   logic [XL-1:0]  wdata_q, wdata_d;
   logic [31:0]    buf_q, buf_d;
   logic [XL-1:0]  mem_a_q, mem_a_d;
   logic [7:0]     mem_dout_q, mem_dout_d;
   logic           mem_wr_q, mem_wr_d;
   logic           data_ready_q, data_ready_d;
   logic [XL-1:0]  data_q, data_d;
   logic [IDW-1:0] id_out_q, id_out_d;
   logic           if_ready_q, if_ready_d;
   logic [31:0]    if_inst_q, if_inst_d;
   logic           pld_valid_q, pld_valid_d;
   logic [OPW-1:0] pld_op_q, pld_op_d;
   logic [XL-1:0]  pld_addr_q, pld_addr_d;
   logic [IDW-1:0] pld_id_q, pld_id_d;
   logic           pst_valid_q, pst_valid_d;
   logic [OPW-1:0] pst_op_q, pst_op_d;
   logic [XL-1:0]  pst_addr_q, pst_addr_d;
   logic [XL-1:0]  pst_data_q, pst_data_d;

   logic [31:0]    word;
   logic [XL-1:0]  ext;
   logic [1:0]     bidx;
   logic [OPW-1:0] st_op, ld_op;
   logic [XL-1:0]  st_addr, st_data, ld_addr, next_a;
   logic [IDW-1:0] ld_id;

   function automatic logic [2:0] op_len(input logic [OPW-1:0] op);
      if (op == `OP_LB || op == `OP_LBU || op == `OP_SB)
         return 3'd1;
      if (op == `OP_LH || op == `OP_LHU || op == `OP_SH)
         return 3'd2;
      return 3'd4;
   endfunction

   assign next_a   = mem_a_q + ONE;
   assign mem_busy = (state_q != IDLE) || pld_valid_q
                     || lsb_mem_enable || rob_store_enable;

   assign mem_a          = mem_a_q;
   assign mem_dout       = mem_dout_q;
   assign mem_wr         = mem_wr_q;
   assign mem_data_ready = data_ready_q;
   assign mem_data       = data_q;
   assign mem_id         = id_out_q;
   assign if_ready       = if_ready_q;
   assign if_inst        = if_inst_q;

   // next-state: arbitration, byte sequencing and load assembly
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      len_d        = len_q;
      op_d         = op_q;
      id_d         = id_q;
      wdata_d      = wdata_q;
      buf_d        = buf_q;
      mem_a_d      = mem_a_q;
      mem_dout_d   = mem_dout_q;
      mem_wr_d     = 1'b0;
      data_ready_d = 1'b0;
      data_d       = data_q;
      id_out_d     = id_out_q;
      if_ready_d   = 1'b0;
      if_inst_d    = if_inst_q;
      pld_valid_d  = pld_valid_q;
      pld_op_d     = pld_op_q;
      pld_addr_d   = pld_addr_q;
      pld_id_d     = pld_id_q;
      pst_valid_d  = pst_valid_q;
      pst_op_d     = pst_op_q;
      pst_addr_d   = pst_addr_q;
      pst_data_d   = pst_data_q;

      st_op   = pst_valid_q ? pst_op_q   : rob_store_op;
      st_addr = pst_valid_q ? pst_addr_q : rob_store_addr;
      st_data = pst_valid_q ? pst_data_q : rob_store_data;
      ld_op   = pld_valid_q ? pld_op_q   : lsb_mem_op;
      ld_addr = pld_valid_q ? pld_addr_q : lsb_mem_addr;
      ld_id   = pld_valid_q ? pld_id_q   : lsb_mem_id;

      bidx = cnt_q[1:0] - 2'd1;
      word = buf_q;
      word[{bidx, 3'b000} +: 8] = mem_din;
      case (op_q)
         `OP_LB:  ext = {{24{word[7]}}, word[7:0]};
         `OP_LH:  ext = {{16{word[15]}}, word[15:0]};
         `OP_LBU: ext = {24'd0, word[7:0]};
         `OP_LHU: ext = {16'd0, word[15:0]};
         default: ext = word;
      endcase

      if (flush)
         pld_valid_d = 1'b0;
      if (lsb_mem_enable && !flush) begin
         pld_valid_d = 1'b1;
         pld_op_d    = lsb_mem_op;
         pld_addr_d  = lsb_mem_addr;
         pld_id_d    = lsb_mem_id;
      end
      if (rob_store_enable) begin
         pst_valid_d = 1'b1;
         pst_op_d    = rob_store_op;
         pst_addr_d  = rob_store_addr;
         pst_data_d  = rob_store_data;
      end

      unique case (state_q)
         IDLE: begin
            if (pst_valid_q || rob_store_enable) begin
               pst_valid_d = pst_valid_q && rob_store_enable;
               state_d     = STORE;
               cnt_d       = 3'd0;
               len_d       = op_len(st_op);
               wdata_d     = st_data;
               mem_a_d     = st_addr;
               mem_dout_d  = st_data[7:0];
               mem_wr_d    = !((st_addr >= IO_ADDR) && io_buffer_full);
            end else if (!flush && (pld_valid_q || lsb_mem_enable)) begin
               pld_valid_d = pld_valid_q && lsb_mem_enable;
               state_d     = LOAD;
               cnt_d       = 3'd0;
               len_d       = op_len(ld_op);
               op_d        = ld_op;
               id_d        = ld_id;
               mem_a_d     = ld_addr;
            end else if (!flush && if_enable && !if_ready_q) begin
               state_d = FETCH;
               cnt_d   = 3'd0;
               len_d   = 3'd4;
               mem_a_d = if_addr;
            end
         end
         LOAD, FETCH: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               if (cnt_q + 3'd1 < len_q)
                  mem_a_d = next_a;
               if (cnt_q != 3'd0)
                  buf_d = word;
               if (cnt_q == len_q) begin
                  state_d = IDLE;
                  if (state_q == LOAD) begin
                     data_ready_d = 1'b1;
                     data_d       = ext;
                     id_out_d     = id_q;
                  end else begin
                     if_ready_d = 1'b1;
                     if_inst_d  = word;
                  end
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         STORE: begin
            if (mem_wr_q) begin
               if (cnt_q == len_q - 3'd1) begin
                  state_d = IDLE;
               end else begin
                  cnt_d      = cnt_q + 3'd1;
                  mem_a_d    = next_a;
                  mem_dout_d = wdata_q[{cnt_d[1:0], 3'b000} +: 8];
                  mem_wr_d   = !((next_a >= IO_ADDR) && io_buffer_full);
               end
            end else begin
               mem_wr_d = !((mem_a_q >= IO_ADDR) && io_buffer_full);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state register: sync reset, hold everything while rdy is low
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         len_q        <= '0;
         op_q         <= '0;
         id_q         <= '0;
         wdata_q      <= '0;
         buf_q        <= '0;
         mem_a_q      <= '0;
         mem_dout_q   <= '0;
         mem_wr_q     <= 1'b0;
         data_ready_q <= 1'b0;
         data_q       <= '0;
         id_out_q     <= '0;
         if_ready_q   <= 1'b0;
         if_inst_q    <= '0;
         pld_valid_q  <= 1'b0;
         pld_op_q     <= '0;
         pld_addr_q   <= '0;
         pld_id_q     <= '0;
         pst_valid_q  <= 1'b0;
         pst_op_q     <= '0;
         pst_addr_q   <= '0;
         pst_data_q   <= '0;
      end else if (rdy) begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         len_q        <= len_d;
         op_q         <= op_d;
         id_q         <= id_d;
         wdata_q      <= wdata_d;
         buf_q        <= buf_d;
         mem_a_q      <= mem_a_d;
         mem_dout_q   <= mem_dout_d;
         mem_wr_q     <= mem_wr_d;
         data_ready_q <= data_ready_d;
         data_q       <= data_d;
         id_out_q     <= id_out_d;
         if_ready_q   <= if_ready_d;
         if_inst_q    <= if_inst_d;
         pld_valid_q  <= pld_valid_d;
         pld_op_q     <= pld_op_d;
         pld_addr_q   <= pld_addr_d;
         pld_id_q     <= pld_id_d;
         pst_valid_q  <= pst_valid_d;
         pst_op_q     <= pst_op_d;
         pst_addr_q   <= pst_addr_d;
         pst_data_q   <= pst_data_d;
      end
   end
endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller: directed and randomized checks of
// memory_controller against a byte-array reference model.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif
`ifndef INST_OP_WIDTH
`define INST_OP_WIDTH 6
`endif
`ifndef OP_LB
`define OP_LB  6'd0
`define OP_LH  6'd1
`define OP_LW  6'd2
`define OP_LBU 6'd3
`define OP_LHU 6'd4
`define OP_SB  6'd5
`define OP_SH  6'd6
`define OP_SW  6'd7
`endif

module tb_memory_controller;
   localparam int AW = 18;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic        flush = 1'b0;
   logic        io_buffer_full = 1'b0;
   logic        lsb_mem_enable = 1'b0;
   logic [5:0]  lsb_mem_op = '0;
   logic [31:0] lsb_mem_addr = '0;
   logic [3:0]  lsb_mem_id = '0;
   logic        rob_store_enable = 1'b0;
   logic [5:0]  rob_store_op = '0;
   logic [31:0] rob_store_addr = '0;
   logic [31:0] rob_store_data = '0;
   logic        if_enable = 1'b0;
   logic [31:0] if_addr = '0;
   logic [7:0]  mem_din = '0;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        mem_busy;
   logic        mem_data_ready;
   logic [31:0] mem_data;
   logic [3:0]  mem_id;
   logic        if_ready;
   logic [31:0] if_inst;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] ram     [0:(1<<AW)-1];
   logic [7:0] ref_mem [0:(1<<AW)-1];

   memory_controller dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .io_buffer_full(io_buffer_full),
      .lsb_mem_enable(lsb_mem_enable), .lsb_mem_op(lsb_mem_op),
      .lsb_mem_addr(lsb_mem_addr), .lsb_mem_id(lsb_mem_id),
      .rob_store_enable(rob_store_enable), .rob_store_op(rob_store_op),
      .rob_store_addr(rob_store_addr), .rob_store_data(rob_store_data),
      .if_enable(if_enable), .if_addr(if_addr),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
      .mem_wr(mem_wr), .mem_busy(mem_busy),
      .mem_data_ready(mem_data_ready), .mem_data(mem_data),
      .mem_id(mem_id), .if_ready(if_ready), .if_inst(if_inst)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // RAM: sample address at the edge, data out next cycle
   always @(posedge clk) begin
      mem_din <= ram[mem_a[AW-1:0]];
      if (mem_wr)
         ram[mem_a[AW-1:0]] <= mem_dout;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int nbytes(input logic [5:0] op);
      if (op == `OP_LB || op == `OP_LBU || op == `OP_SB) return 1;
      if (op == `OP_LH || op == `OP_LHU || op == `OP_SH) return 2;
      return 4;
   endfunction

   function automatic logic [AW-1:0] ix(input logic [31:0] a);
      return a[AW-1:0];
   endfunction

   function automatic logic [31:0] ref_load(input logic [5:0] op,
                                            input logic [31:0] a);
      longint v;
      int n;
      n = nbytes(op);
      v = 0;
      for (int k = 0; k < n; k++)
         v += longint'(ref_mem[ix(a + 32'(k))]) << (8 * k);
      if ((op == `OP_LB || op == `OP_LH)
          && v >= (longint'(1) << (8 * n - 1)))
         v -= longint'(1) << (8 * n);
      return v[31:0];
   endfunction

   task automatic do_load(input string tag, input logic [5:0] op,
                          input logic [31:0] a, input logic [3:0] id,
                          input int flush_at);
      int n, pulses, lat;
      logic [31:0] got_d, exp_d;
      logic [3:0] got_id;
      n = nbytes(op);
      exp_d = ref_load(op, a);
      pulses = 0;
      lat = -1;
      got_d = '0;
      got_id = '0;
      lsb_mem_enable = 1'b1;
      lsb_mem_op = op;
      lsb_mem_addr = a;
      lsb_mem_id = id;
      for (int t = 1; t <= n + 6; t++) begin
         step();
         lsb_mem_enable = 1'b0;
         flush = (t == flush_at);
         if (t <= n && (flush_at == 0 || t <= flush_at))
            chk({tag, " mem_a"}, mem_a, a + 32'(t - 1));
         if (flush_at != 0 && t == flush_at + 1)
            chk({tag, " busy_after_flush"}, 32'(mem_busy), 0);
         if (mem_data_ready) begin
            pulses++;
            if (lat < 0) begin
               lat = t;
               got_d = mem_data;
               got_id = mem_id;
            end
         end
      end
      flush = 1'b0;
      if (flush_at != 0) begin
         chk({tag, " pulses"}, 32'(pulses), 0);
      end else begin
         chk({tag, " pulses"}, 32'(pulses), 1);
         chk({tag, " latency"}, 32'(lat), 32'(n + 2));
         chk({tag, " data"}, got_d, exp_d);
         chk({tag, " id"}, 32'(got_id), 32'(id));
      end
   endtask

   task automatic do_store(input string tag, input logic [5:0] op,
                           input logic [31:0] a, input logic [31:0] d,
                           input int io_cycles, input int flush_at);
      int n, base, nw;
      n = nbytes(op);
      base = (io_cycles > 0) ? io_cycles + 1 : 1;
      nw = 0;
      rob_store_enable = 1'b1;
      rob_store_op = op;
      rob_store_addr = a;
      rob_store_data = d;
      io_buffer_full = (io_cycles > 0);
      for (int t = 1; t <= base + n + 4; t++) begin
         step();
         rob_store_enable = 1'b0;
         io_buffer_full = (t < io_cycles);
         flush = (t == flush_at);
         if (mem_wr) begin
            if (nw < n) begin
               chk({tag, " wr_cycle"}, 32'(t), 32'(base + nw));
               chk({tag, " wr_addr"}, mem_a, a + 32'(nw));
               chk({tag, " wr_byte"}, 32'(mem_dout), 32'(d[8 * nw +: 8]));
            end
            nw++;
         end
      end
      flush = 1'b0;
      io_buffer_full = 1'b0;
      chk({tag, " wr_count"}, 32'(nw), 32'(n));
      for (int k = 0; k < n; k++)
         ref_mem[ix(a + 32'(k))] = d[8 * k +: 8];
   endtask

   task automatic do_fetch(input string tag, input logic [31:0] a);
      int pulses, lat;
      logic [31:0] got, exp_i;
      exp_i = ref_load(`OP_LW, a);
      pulses = 0;
      lat = -1;
      got = '0;
      if_enable = 1'b1;
      if_addr = a;
      for (int t = 1; t <= 12; t++) begin
         step();
         if_addr = $urandom;
         if (t <= 4)
            chk({tag, " mem_a"}, mem_a, a + 32'(t - 1));
         if (if_ready) begin
            pulses++;
            if (lat < 0) begin
               lat = t;
               got = if_inst;
            end
            if_enable = 1'b0;
         end
      end
      if_enable = 1'b0;
      chk({tag, " pulses"}, 32'(pulses), 1);
      chk({tag, " latency"}, 32'(lat), 6);
      chk({tag, " inst"}, got, exp_i);
   endtask

   initial begin
      logic [5:0] ops [0:7];
      int busy_cnt, nw, pulses, lat, bad;
      logic [31:0] got_d, exp_d;
      logic [3:0] got_id;
      ops = '{`OP_LB, `OP_LH, `OP_LW, `OP_LBU, `OP_LHU,
              `OP_SB, `OP_SH, `OP_SW};

      for (int i = 0; i < (1 << AW); i++) begin
         ram[i] = 8'($urandom);
         ref_mem[i] = ram[i];
      end
      ram[18'h100] = 8'h78; ram[18'h101] = 8'h56;
      ram[18'h102] = 8'h34; ram[18'h103] = 8'h12;
      ram[18'h200] = 8'h80;
      for (int i = 0; i < 4; i++)
         ref_mem[18'h100 + i] = ram[18'h100 + i];
      ref_mem[18'h200] = 8'h80;

      rst = 1'b1;
      repeat (3) step();
      chk("rst mem_wr", 32'(mem_wr), 0);
      chk("rst mem_a", mem_a, 0);
      chk("rst mem_dout", 32'(mem_dout), 0);
      chk("rst mem_busy", 32'(mem_busy), 0);
      chk("rst data_ready", 32'(mem_data_ready), 0);
      chk("rst mem_data", mem_data, 0);
      chk("rst mem_id", 32'(mem_id), 0);
      chk("rst if_ready", 32'(if_ready), 0);
      chk("rst if_inst", if_inst, 0);
      rst = 1'b0;

      while (cyc < 10) step();
      do_load("lw_100", `OP_LW, 32'h100, 4'd5, 0);
      chk("lw_100 value", ref_load(`OP_LW, 32'h100), 32'h12345678);
      do_load("lb_200", `OP_LB, 32'h200, 4'd1, 0);
      do_load("lbu_200", `OP_LBU, 32'h200, 4'd2, 0);
      do_load("lw_wrap", `OP_LW, 32'hFFFF_FFFE, 4'd7, 0);

      rob_store_enable = 1'b1;
      rob_store_op = `OP_SH;
      rob_store_addr = 32'h40;
      rob_store_data = 32'h0000_ABCD;
      lsb_mem_enable = 1'b1;
      lsb_mem_op = `OP_LW;
      lsb_mem_addr = 32'h80;
      lsb_mem_id = 4'd3;
      ref_mem[18'h40] = 8'hCD;
      ref_mem[18'h41] = 8'hAB;
      exp_d = ref_load(`OP_LW, 32'h80);
      busy_cnt = 0;
      nw = 0;
      pulses = 0;
      lat = -1;
      got_d = '0;
      got_id = '0;
      for (int t = 1; t <= 14; t++) begin
         step();
         rob_store_enable = 1'b0;
         lsb_mem_enable = 1'b0;
         if (t <= 8 && mem_busy) busy_cnt++;
         if (t == 9) chk("sh_lw busy_release", 32'(mem_busy), 0);
         if (mem_wr) begin
            if (nw < 2) begin
               chk("sh_lw wr_cycle", 32'(t), 32'(1 + nw));
               chk("sh_lw wr_addr", mem_a, 32'h40 + 32'(nw));
            end
            if (nw == 0) chk("sh_lw byte0", 32'(mem_dout), 32'hCD);
            if (nw == 1) chk("sh_lw byte1", 32'(mem_dout), 32'hAB);
            nw++;
         end
         if (mem_data_ready) begin
            pulses++;
            if (lat < 0) begin
               lat = t;
               got_d = mem_data;
               got_id = mem_id;
            end
         end
      end
      chk("sh_lw busy", 32'(busy_cnt), 8);
      chk("sh_lw wr_count", 32'(nw), 2);
      chk("sh_lw pulses", 32'(pulses), 1);
      chk("sh_lw latency", 32'(lat), 9);
      chk("sh_lw data", got_d, exp_d);
      chk("sh_lw id", 32'(got_id), 3);

      do_store("sb_io", `OP_SB, 32'h30000, 32'h0000_005A, 4, 0);
      do_load("lw_flush", `OP_LW, 32'h100, 4'd6, 2);
      do_store("sw_flush", `OP_SW, 32'h300, 32'hDEAD_BEEF, 0, 2);
      do_load("lw_after_sw", `OP_LW, 32'h300, 4'd9, 0);

      if_enable = 1'b1;
      if_addr = 32'h100;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      if_enable = 1'b0;
      chk("rst_fetch mem_wr", 32'(mem_wr), 0);
      chk("rst_fetch if_ready", 32'(if_ready), 0);
      chk("rst_fetch busy", 32'(mem_busy), 0);
      do_fetch("fetch_0", 32'h0);

      for (int i = 0; i < 30; i++) begin
         int kind;
         logic [31:0] a, d;
         kind = $urandom_range(0, 8);
         a = $urandom_range(0, 1023);
         d = $urandom;
         if (kind < 5)
            do_load("rnd_ld", ops[kind], a, 4'($urandom_range(0, 15)), 0);
         else if (kind < 8)
            do_store("rnd_st", ops[kind], a, d, 0, 0);
         else
            do_fetch("rnd_if", a);
         repeat ($urandom_range(0, 2)) step();
      end

      repeat (4) step();
      bad = 0;
      for (int i = 0; i < (1 << AW); i++)
         if (ram[i] !== ref_mem[i]) bad++;
      chk("ram_image", 32'(bad), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
